// File: rtl/app_frac_det.sv
// Multi-channel ring fracture detector: threshold, debounce, sticky status, event counters, masked irq.
// Latency: status/counters update on the qualifying sample edge; fx_q 1 cycle after fx_rd; irq_frac 1 cycle after status/mask.
// No backpressure: samples and fx accesses are accepted every cycle; fx_q holds between reads.
module app_frac_det #(
  parameter int          NCH       = 8,
  parameter int          DW        = 16,
  parameter int          CNT_W     = 8,
  parameter logic [21:0] BASE_ADDR = 22'h000100
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [NCH*DW-1:0] ph_ring,
  input  logic [NCH-1:0]    ph_vld,
  input  logic [21:0]       fx_waddr,
  input  logic              fx_wr,
  input  logic [7:0]        fx_data,
  input  logic [21:0]       fx_raddr,
  input  logic              fx_rd,
  output logic [7:0]        fx_q,
  output logic [NCH-1:0]    stu_frac,
  output logic              irq_frac
);

  localparam logic [21:0] NREG = 22'(8 + NCH);

  logic [15:0]          ring_th;
  logic [7:0]           deb_len;
  logic [7:0]           ctrl;
  logic [NCH-1:0]       irq_mask;
  logic [7:0]           deb_eff;
  logic [21:0]          woff;
  logic [21:0]          roff;
  logic                 wsel;
  logic [NCH-1:0]       clr_stu;
  logic [NCH-1:0]       clr_cnt;
  logic [NCH-1:0]       evt;
  logic [NCH*CNT_W-1:0] cnt_flat;
  logic [7:0]           rd_dat;

  // Byte offsets relative to the block base; out-of-window accesses fall through
  assign woff    = fx_waddr - BASE_ADDR;
  assign roff    = fx_raddr - BASE_ADDR;
  assign wsel    = fx_wr && (woff < NREG);
  assign clr_stu = (wsel && woff == 22'd4) ? fx_data[NCH-1:0] : '0;
  assign clr_cnt = (wsel && woff == 22'd7) ? fx_data[NCH-1:0] : '0;
  // A debounce length of zero behaves as a single-sample debounce
  assign deb_eff = (deb_len == 8'd0) ? 8'd1 : deb_len;

  // Configuration registers written from the fx bus
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ring_th  <= 16'h8000;
      deb_len  <= 8'd4;
      ctrl     <= 8'h01;
      irq_mask <= '0;
    end else if (wsel) begin
      case (woff)
        22'd0:   ring_th[7:0]  <= fx_data;
        22'd1:   ring_th[15:8] <= fx_data;
        22'd2:   deb_len       <= fx_data;
        22'd5:   ctrl          <= fx_data;
        22'd6:   irq_mask      <= fx_data[NCH-1:0];
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW-1:0]    smp;
    logic             hit;
    logic [7:0]       run_cnt;
    logic [7:0]       run_inc;
    logic             armed;
    logic [CNT_W-1:0] evt_cnt;

    assign smp     = ph_ring[k*DW +: DW];
    assign hit     = ctrl[1] ? (smp < ring_th[DW-1:0]) : (smp > ring_th[DW-1:0]);
    assign run_inc = (run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1;
    // Only the sample that lands exactly on the debounce length fires, and only once per run
    assign evt[k]  = ctrl[0] && ph_vld[k] && hit && armed && (run_inc == deb_eff);
    assign cnt_flat[k*CNT_W +: CNT_W] = evt_cnt;

    // Run-length tracking; disable or a miss restarts the run and re-arms
    always_ff @(posedge clk_sys) begin
      if (rst || !ctrl[0]) begin
        run_cnt <= 8'd0;
        armed   <= 1'b1;
      end else if (ph_vld[k]) begin
        if (hit) begin
          run_cnt <= run_inc;
          if (evt[k]) armed <= 1'b0;
        end else begin
          run_cnt <= 8'd0;
          armed   <= 1'b1;
        end
      end
    end

    // Saturating event counter; a clear racing an increment leaves one count
    always_ff @(posedge clk_sys) begin
      if (rst) begin
        evt_cnt <= '0;
      end else if (evt[k]) begin
        if (clr_cnt[k])                 evt_cnt <= CNT_W'(1);
        else if (evt_cnt != '1)         evt_cnt <= evt_cnt + CNT_W'(1);
      end else if (clr_cnt[k]) begin
        evt_cnt <= '0;
      end
    end
  end

  // Sticky status; a new event beats a same-cycle clear
  always_ff @(posedge clk_sys) begin
    if (rst) stu_frac <= '0;
    else     stu_frac <= (stu_frac & ~clr_stu) | evt;
  end

  // Interrupt follows masked status one cycle later
  always_ff @(posedge clk_sys) begin
    if (rst) irq_frac <= 1'b0;
    else     irq_frac <= |(stu_frac & irq_mask);
  end

  // Read mux; strobe registers and unmapped offsets read as zero
  always_comb begin
    rd_dat = 8'h00;
    case (roff)
      22'd0: rd_dat = ring_th[7:0];
      22'd1: rd_dat = ring_th[15:8];
      22'd2: rd_dat = deb_len;
      22'd3: rd_dat[NCH-1:0] = stu_frac;
      22'd5: rd_dat = ctrl;
      22'd6: rd_dat[NCH-1:0] = irq_mask;
      default: begin
        for (int k = 0; k < NCH; k++) begin
          if (roff == 22'(8 + k)) rd_dat = cnt_flat[k*CNT_W +: CNT_W];
        end
      end
    endcase
  end

  // Registered read data, held while no read is issued
  always_ff @(posedge clk_sys) begin
    if (rst)        fx_q <= 8'h00;
    else if (fx_rd) fx_q <= rd_dat;
  end

endmodule

// File: tb/tb_app_frac_det.sv
module tb_app_frac_det;
  localparam int          NCH  = 8;
  localparam int          DW   = 16;
  localparam logic [21:0] BASE = 22'h000100;

  logic              clk_sys = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] ph_ring;
  logic [NCH-1:0]    ph_vld;
  logic [21:0]       fx_waddr, fx_raddr;
  logic              fx_wr, fx_rd;
  logic [7:0]        fx_data;
  logic [7:0]        fx_q;
  logic [NCH-1:0]    stu_frac;
  logic              irq_frac;

  app_frac_det #(.NCH(NCH), .DW(DW), .CNT_W(8), .BASE_ADDR(BASE)) dut (
    .clk_sys(clk_sys), .rst(rst), .ph_ring(ph_ring), .ph_vld(ph_vld),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q),
    .stu_frac(stu_frac), .irq_frac(irq_frac)
  );

  always #5 clk_sys = ~clk_sys;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  // Reference model state: register image plus per-channel consecutive-hit counts
  logic [15:0]    m_th;
  logic [7:0]     m_deb, m_ctrl, m_q;
  logic [NCH-1:0] m_mask, m_stu;
  logic           m_irq;
  int             m_cnt [NCH];
  int             m_run [NCH];
  bit             m_armed [NCH];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] model_read(logic [21:0] a);
    logic [21:0] o;
    o = a - BASE;
    case (o)
      22'd0: return m_th[7:0];
      22'd1: return m_th[15:8];
      22'd2: return m_deb;
      22'd3: return 8'(m_stu);
      22'd5: return m_ctrl;
      22'd6: return 8'(m_mask);
      default: begin
        if (o >= 22'd8 && o < 22'(8 + NCH)) return 8'(m_cnt[int'(o) - 8]);
        return 8'h00;
      end
    endcase
  endfunction

  task automatic model_tick();
    logic [NCH-1:0] evt, clr_s, clr_c;
    logic [21:0]    o;
    logic [DW-1:0]  s;
    int             need;
    bit             hit;
    logic           irq_n;
    evt = '0; clr_s = '0; clr_c = '0;
    if (fx_rd) m_q = model_read(fx_raddr);
    irq_n = |(m_stu & m_mask);
    need  = (m_deb == 0) ? 1 : int'(m_deb);
    for (int k = 0; k < NCH; k++) begin
      if (!m_ctrl[0]) begin
        m_run[k] = 0; m_armed[k] = 1;
      end else if (ph_vld[k]) begin
        s   = ph_ring[k*DW +: DW];
        hit = m_ctrl[1] ? (int'(s) < int'(m_th[DW-1:0])) : (int'(s) > int'(m_th[DW-1:0]));
        if (hit) begin
          if (m_run[k] < 255) m_run[k]++;
          if (m_run[k] == need && m_armed[k]) begin evt[k] = 1; m_armed[k] = 0; end
        end else begin
          m_run[k] = 0; m_armed[k] = 1;
        end
      end
    end
    o = fx_waddr - BASE;
    if (fx_wr) begin
      case (o)
        22'd0: m_th[7:0]  = fx_data;
        22'd1: m_th[15:8] = fx_data;
        22'd2: m_deb      = fx_data;
        22'd4: clr_s      = fx_data[NCH-1:0];
        22'd5: m_ctrl     = fx_data;
        22'd6: m_mask     = fx_data[NCH-1:0];
        22'd7: clr_c      = fx_data[NCH-1:0];
        default: ;
      endcase
    end
    for (int k = 0; k < NCH; k++) begin
      if (evt[k]) begin
        m_stu[k] = 1'b1;
        m_cnt[k] = clr_c[k] ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
      end else begin
        if (clr_s[k]) m_stu[k] = 1'b0;
        if (clr_c[k]) m_cnt[k] = 0;
      end
    end
    m_irq = irq_n;
    if (rst) begin
      m_th = 16'h8000; m_deb = 8'd4; m_ctrl = 8'h01; m_mask = '0; m_stu = '0;
      m_irq = 1'b0; m_q = 8'h00;
      for (int k = 0; k < NCH; k++) begin m_cnt[k] = 0; m_run[k] = 0; m_armed[k] = 1; end
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_tick();
    #1;
    if (chk_en) begin
      check("stu_frac", 32'(stu_frac), 32'(m_stu));
      check("irq_frac", 32'(irq_frac), 32'(m_irq));
      check("fx_q", 32'(fx_q), 32'(m_q));
    end
  endtask

  task automatic wr(int off, logic [7:0] d);
    fx_waddr = BASE + 22'(off); fx_data = d; fx_wr = 1'b1;
    step();
    fx_wr = 1'b0;
  endtask

  task automatic rdchk(string name, int off, logic [7:0] exp);
    fx_raddr = BASE + 22'(off); fx_rd = 1'b1;
    step();
    fx_rd = 1'b0;
    check(name, 32'(fx_q), 32'(exp));
  endtask

  task automatic smp(int ch, int val);
    ph_vld = '0; ph_vld[ch] = 1'b1;
    ph_ring[ch*DW +: DW] = DW'(val);
    step();
    ph_vld = '0;
  endtask

  typedef struct {
    bit         is_wr;
    int         off;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [21:0] o;
    int          r;
    rst = 1'b1; ph_ring = '0; ph_vld = '0;
    fx_waddr = '0; fx_raddr = '0; fx_wr = 0; fx_rd = 0; fx_data = '0;

    // Register map: reset values, RW/RO/W1C/unmapped behaviour
    tbl.push_back('{0, 0, 8'h00, 8'h00});
    tbl.push_back('{0, 1, 8'h00, 8'h80});
    tbl.push_back('{0, 2, 8'h00, 8'h04});
    tbl.push_back('{0, 3, 8'h00, 8'h00});
    tbl.push_back('{0, 4, 8'h00, 8'h00});
    tbl.push_back('{0, 5, 8'h00, 8'h01});
    tbl.push_back('{0, 6, 8'h00, 8'h00});
    tbl.push_back('{0, 7, 8'h00, 8'h00});
    tbl.push_back('{0, 8, 8'h00, 8'h00});
    tbl.push_back('{0, 15, 8'h00, 8'h00});
    tbl.push_back('{0, 16, 8'h00, 8'h00});
    tbl.push_back('{0, -1, 8'h00, 8'h00});
    tbl.push_back('{1, 6, 8'hA5, 8'h00});
    tbl.push_back('{0, 6, 8'h00, 8'hA5});
    tbl.push_back('{1, 16, 8'hFF, 8'h00});
    tbl.push_back('{0, 16, 8'h00, 8'h00});
    tbl.push_back('{1, 3, 8'hFF, 8'h00});
    tbl.push_back('{0, 3, 8'h00, 8'h00});
    tbl.push_back('{1, 8, 8'h55, 8'h00});
    tbl.push_back('{0, 8, 8'h00, 8'h00});
    tbl.push_back('{1, 4, 8'hFF, 8'h00});
    tbl.push_back('{0, 4, 8'h00, 8'h00});
    tbl.push_back('{1, 6, 8'h00, 8'h00});
    tbl.push_back('{1, 0, 8'hE8, 8'h00});
    tbl.push_back('{1, 1, 8'h03, 8'h00});
    tbl.push_back('{0, 0, 8'h00, 8'hE8});
    tbl.push_back('{0, 1, 8'h00, 8'h03});
    tbl.push_back('{0, 6, 8'h00, 8'h00});

    step(); step();
    rst = 1'b0;
    chk_en = 1;
    check("rst_irq", 32'(irq_frac), 32'h0);
    check("rst_stu", 32'(stu_frac), 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) wr(tbl[i].off, tbl[i].dat);
      else rdchk($sformatf("vec%0d", i), tbl[i].off, tbl[i].exp);
    end

    // Debounce: fires on the 4th hit, not the 3rd, and only once
    for (int i = 0; i < 3; i++) smp(2, 1001);
    check("t2_no_early", 32'(stu_frac[2]), 32'h0);
    smp(2, 1001);
    check("t2_fire", 32'(stu_frac[2]), 32'h1);
    rdchk("t2_cnt", 10, 8'd1);
    smp(2, 1001);
    rdchk("t2_no_extra", 10, 8'd1);

    // Rearm on equality (miss) and polarity mode
    for (int i = 0; i < 4; i++) smp(0, 1001);
    smp(0, 1000);
    for (int i = 0; i < 4; i++) smp(0, 1001);
    rdchk("t3_rearm", 8, 8'd2);
    wr(5, 8'h03);
    smp(0, 1000);
    for (int i = 0; i < 4; i++) smp(0, 999);
    rdchk("t3_mode1", 8, 8'd3);
    for (int i = 0; i < 4; i++) smp(0, 1001);
    rdchk("t3_mode1_above", 8, 8'd3);
    wr(5, 8'h01);

    // Clear races: set beats clear, increment plus clear gives one
    smp(0, 1000);
    for (int i = 0; i < 3; i++) smp(0, 1001);
    ph_vld = 8'h01; ph_ring[0 +: DW] = 16'd1001;
    fx_waddr = BASE + 22'd4; fx_data = 8'h01; fx_wr = 1'b1;
    step();
    fx_wr = 1'b0; ph_vld = '0;
    check("t4_set_wins", 32'(stu_frac[0]), 32'h1);
    smp(0, 1000);
    for (int i = 0; i < 3; i++) smp(0, 1001);
    ph_vld = 8'h01;
    fx_waddr = BASE + 22'd7; fx_data = 8'h01; fx_wr = 1'b1;
    step();
    fx_wr = 1'b0; ph_vld = '0;
    rdchk("t4_cnt_race", 8, 8'd1);

    // Interrupt timing and mask
    wr(6, 8'h80);
    for (int i = 0; i < 4; i++) smp(7, 1001);
    check("t5_stu7", 32'(stu_frac[7]), 32'h1);
    check("t5_irq_lag", 32'(irq_frac), 32'h0);
    step();
    check("t5_irq_set", 32'(irq_frac), 32'h1);
    wr(4, 8'h80);
    check("t5_stu7_clr", 32'(stu_frac[7]), 32'h0);
    step();
    check("t5_irq_clr", 32'(irq_frac), 32'h0);

    // Counter saturation with single-sample debounce, and deb_len=0 acting as 1
    wr(2, 8'd1);
    for (int i = 0; i < 300; i++) begin smp(1, 1001); smp(1, 1000); end
    rdchk("t5_sat", 9, 8'd255);
    wr(2, 8'd0);
    smp(4, 1001);
    rdchk("t5_deb0", 12, 8'd1);
    wr(2, 8'd4);

    // Disable mid-run discards the run; reset mid-run discards everything
    for (int i = 0; i < 3; i++) smp(3, 1001);
    wr(5, 8'h00);
    wr(5, 8'h01);
    smp(3, 1001);
    check("t6_dis_noevt", 32'(stu_frac[3]), 32'h0);
    rdchk("t6_dis_cnt", 11, 8'd0);
    smp(3, 1001); smp(3, 1001);
    rst = 1'b1; step(); step(); rst = 1'b0;
    check("t6_rst_stu", 32'(stu_frac), 32'h0);
    check("t6_rst_irq", 32'(irq_frac), 32'h0);
    rdchk("t6_rst_th_hi", 1, 8'h80);
    rdchk("t6_rst_deb", 2, 8'h04);
    rdchk("t6_rst_cnt0", 8, 8'h00);
    rdchk("t6_rst_cnt1", 9, 8'h00);
    smp(3, 16'h8001);
    check("t6_rst_run", 32'(stu_frac[3]), 32'h0);
    for (int i = 0; i < 3; i++) smp(3, 16'h8001);
    check("t6_post_rst_evt", 32'(stu_frac[3]), 32'h1);

    // Randomized traffic against the reference model
    wr(0, 8'hE8); wr(1, 8'h03); wr(2, 8'd2);
    for (int it = 0; it < 3000; it++) begin
      ph_vld = NCH'($urandom);
      for (int k = 0; k < NCH; k++) begin
        r = $urandom_range(0, 3);
        case (r)
          0: ph_ring[k*DW +: DW] = m_th[DW-1:0] - DW'(1);
          1: ph_ring[k*DW +: DW] = m_th[DW-1:0];
          2: ph_ring[k*DW +: DW] = m_th[DW-1:0] + DW'(1);
          default: ph_ring[k*DW +: DW] = DW'($urandom);
        endcase
      end
      fx_wr = ($urandom_range(0, 11) == 0);
      o = 22'($urandom_range(0, 18)) - 22'd1;
      fx_waddr = BASE + o;
      fx_data = 8'($urandom);
      if (o == 22'd2) fx_data = 8'($urandom_range(0, 5));
      if (o == 22'd5) fx_data = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3) & 2) : 8'(1 | ($urandom_range(0, 1) << 1));
      fx_rd = 1'($urandom_range(0, 1));
      fx_raddr = BASE + 22'($urandom_range(0, 18)) - 22'd1;
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0; fx_wr = 1'b0; fx_rd = 1'b0; ph_vld = '0;
    for (int k = 0; k < NCH; k++) rdchk($sformatf("rnd_cnt%0d", k), 8 + k, 8'(m_cnt[k]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
